uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: serial line in, one received byte out.
- Downstream partner of uart_tx on the serial line, with the same baud generation scheme (system clock / baud rate).
- Closes the hex loopback path: uart_done drives uart_tx_en directly, and uart_data drives uart_tx's uart_data.
- Frame format 8N1, LSB first. Start bit is validated at mid-bit and the stop bit is checked.

Parameters:
- SYS_CLK_FRE, 50_000_000, system clock frequency in Hz.
- BPS, 57600, baud rate. Derived localparams: BPS_CNT = SYS_CLK_FRE/BPS (868 with defaults), HALF_CNT = BPS_CNT/2 (434). BPS_CNT must be at least 16.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- uart_rxd  in  1  serial input; asynchronous to sys_clk; idles high.
- uart_data  out  8  last correctly framed byte; held until the next good frame.
- uart_done  out  1  one-cycle pulse; uart_data is valid in the same cycle.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, counters=0, shift register=0, uart_data=8'h00, uart_done=0, frame_err=0, synchronizer flops=1. Asserting reset mid-frame aborts the frame; no pulse is produced.
- Input path: two-flop synchronizer rxd_s1→rxd_s2, plus history flop rxd_s3. fall = rxd_s3 & ~rxd_s2.
- Counters: clk_cnt is 16-bit and counts 0..BPS_CNT-1. bit_cnt is 3-bit.
- IDLE: clk_cnt=0. On fall → START.
- START: count to HALF_CNT-1, then sample rxd_s2.
  - Sample 0 → DATA, clk_cnt=0, bit_cnt=0.
  - Sample 1 → glitch; go to IDLE with no output.
- DATA: at each clk_cnt==BPS_CNT-1 (bit centre):
  - shift[bit_cnt] <= sample; clk_cnt=0.
  - bit_cnt 7 → STOP; otherwise bit_cnt+1.
- STOP: at clk_cnt==BPS_CNT-1, sample the stop bit.
  - Sample 1 → uart_data<=shift, uart_done=1 for that one registered cycle.
  - Sample 0 → frame_err=1 for one cycle; uart_data unchanged.
  - Either way → IDLE in the next cycle, i.e. at mid stop bit. A start edge arriving right after the stop bit is therefore caught.
- Latency: uart_done rises HALF_CNT + 9*BPS_CNT cycles after the fall-detect cycle, plus a 1-cycle register delay. Fall detect itself trails the line edge by 3 cycles.
- Break or stuck-low line: produces one frame_err. No new frame starts until the line returns high and falls again.
- uart_done and frame_err are never asserted together.
- A fall seen outside IDLE is ignored.

Optional Feature:
- UART_RX_MAJORITY_EN defined: each start, data and stop decision is the 2-of-3 majority of rxd_s2 sampled in the three consecutive cycles ending at the nominal sample point. Decision timing and output timing are unchanged.
- Not defined: single sample of rxd_s2 at the nominal point.

Decomposition:
- Package uart_pkg, shared with uart_tx:
  - SYS_CLK_FRE and BPS defaults;
  - rx_state_t enum {IDLE, START, DATA, STOP}, 2-bit.
- Sub-module uart_rx_sync: the 2-flop synchronizer and falling-edge detector. Outputs rxd_s2 and fall; flops reset to 1.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
- Drive 0xA5 at 57600 baud with 868-cycle bits → exactly one uart_done pulse; uart_data=8'hA5; frame_err stays 0; latency matches the formula ±1 cycle.
- Send 0x00 then 0xFF back-to-back with no idle gap → two uart_done pulses 8680 cycles apart; data 8'h00 then 8'hFF.
- Drive a 200-cycle low glitch on an idle line → no uart_done, no frame_err; state returns to IDLE after 434 cycles.
- Send 0x3C with the stop bit forced 0, after a good 0xA5 → one frame_err pulse, no uart_done; uart_data stays 8'hA5.
- Assert sys_rst_n low during data bit 4 → all outputs 0 immediately; then a clean 0x5A → uart_done with uart_data=8'h5A.
- Loopback uart_tx→uart_rx, with tx sending 0x12 → rx uart_done and uart_data=8'h12.
  - With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at a bit centre is ignored (data still 8'h12).
  - Without the macro, the same glitch flips that bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud generation constants and the receiver state encoding.
package uart_pkg;

    localparam int SYS_CLK_FRE = 50_000_000;
    localparam int BPS         = 57600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 2-of-3 vote used by the filtered-sampling receiver build.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a history flop for falling-edge detection.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rxd_s2,
    output logic fall
);

    logic rxd_s1;
    logic rxd_s3;

    // Flops reset to the idle-high line level so leaving reset never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a true 3-stage shift; blocking would collapse it.
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    assign fall = rxd_s3 & ~rxd_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with start validation and stop-bit check.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the last three synchronized samples.
module uart_rx #(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 57600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err
);
    import uart_pkg::*;

    localparam int          BPS_CNT   = SYS_CLK_FRE / BPS;
    localparam int          HALF_CNT  = BPS_CNT / 2;
    localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

    rx_state_t   state, state_nxt;
    logic [15:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [7:0]  data_nxt;
    logic        done_nxt;
    logic        err_nxt;
    logic        rxd_s2;
    logic        fall;
    logic        sample_bit;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rxd_s2    (rxd_s2),
        .fall      (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rxd_hist;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rxd_hist <= 2'b11;
        else            rxd_hist <= {rxd_hist[0], rxd_s2};
    end

    assign sample_bit = maj3({rxd_hist, rxd_s2});
`else
    assign sample_bit = rxd_s2;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_data <= '0;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            uart_data <= data_nxt;
            uart_done <= done_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + 16'd1;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        data_nxt    = uart_data;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                if (fall) state_nxt = START;
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    // A high line at mid start bit was only a glitch.
                    state_nxt   = sample_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BPS_LAST) begin
                    clk_cnt_nxt        = '0;
                    shift_nxt[bit_cnt] = sample_bit;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                    else                 bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            STOP: begin
                if (clk_cnt == BPS_LAST) begin
                    clk_cnt_nxt = '0;
                    // Returning to IDLE at mid stop bit lets a back-to-back start edge be caught.
                    state_nxt   = IDLE;
                    if (sample_bit) begin
                        data_nxt = shift_reg;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
